// File: rtl/signed_minmax_pkg.sv
// Shared state encoding for the signed min/max frame controller.
package signed_minmax_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FIRST = 2'd1;
    localparam logic [1:0] ST_ACCUM = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FIRST = ST_FIRST,
        ACCUM = ST_ACCUM,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/signed_comparator.sv
// Two's complement magnitude compare: is_a_greater is high when a > b.
module signed_comparator #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            is_a_greater
);

    assign is_a_greater = $signed(a) > $signed(b);

endmodule

// File: rtl/signed_minmax_controller.sv
// Streams one frame of signed samples and reports the max/min value, their
// first positions and the sample count, with a valid/ready result handshake.
//
// state | meaning
// IDLE  | waiting for start, previous results held
// FIRST | waiting for the first sample, which seeds max/min
// ACCUM | folding further samples into the running max/min
// DONE  | result presented until the consumer takes it
module signed_minmax_controller
    import signed_minmax_pkg::*;
#(
    parameter  int SIZE  = 8,
    parameter  int COUNT = 8,
    localparam int IDX_W = ($clog2(COUNT) == 0) ? 1 : $clog2(COUNT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SIZE-1:0]    in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SIZE-1:0]    max_val,
    output logic [SIZE-1:0]    min_val,
    output logic [IDX_W-1:0]   max_idx,
    output logic [IDX_W-1:0]   min_idx,
    output logic [IDX_W:0]     count,
    output logic               busy
);

    localparam logic [IDX_W:0] COUNT_FULL = (IDX_W + 1)'(COUNT);
    localparam bit             SINGLE     = (COUNT == 1);

    state_t           state_q, state_d;
    logic             in_hs;
    logic             max_gt, min_gt;
    logic [IDX_W:0]   count_inc;

    assign in_hs     = in_valid & in_ready;
    assign count_inc = count + (IDX_W + 1)'(1);
    assign busy      = (state_q != IDLE);

    signed_comparator #(.SIZE(SIZE)) u_cmp_max (
        .a            (in_data),
        .b            (max_val),
        .is_a_greater (max_gt)
    );

    signed_comparator #(.SIZE(SIZE)) u_cmp_min (
        .a            (min_val),
        .b            (in_data),
        .is_a_greater (min_gt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // in_ready is a pure function of state so there is no in_valid -> in_ready path
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = FIRST;
            end
            FIRST: begin
                in_ready = 1'b1;
                if (in_valid) state_d = (in_last || SINGLE) ? DONE : ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && (in_last || (count_inc == COUNT_FULL))) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strict compares only, so a tie keeps the earliest index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_val <= '0;
            min_val <= '0;
            max_idx <= '0;
            min_idx <= '0;
            count   <= '0;
        end else if (in_hs) begin
            if (state_q == FIRST) begin
                max_val <= in_data;
                min_val <= in_data;
                max_idx <= '0;
                min_idx <= '0;
                count   <= (IDX_W + 1)'(1);
            end else begin
                count <= count_inc;
                if (max_gt) begin
                    max_val <= in_data;
                    max_idx <= count[IDX_W-1:0];
                end
                if (min_gt) begin
                    min_val <= in_data;
                    min_idx <= count[IDX_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_signed_minmax_controller.sv
// Directed bench for signed_minmax_controller: a COUNT=4 instance for the
// frame scenarios and a COUNT=1 instance for the single-sample corner.
module tb_signed_minmax_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // COUNT=4 instance
    logic       start_a, in_valid_a, in_ready_a, in_last_a, out_valid_a, out_ready_a, busy_a;
    logic [7:0] in_data_a, max_val_a, min_val_a;
    logic [1:0] max_idx_a, min_idx_a;
    logic [2:0] count_a;

    // COUNT=1 instance
    logic       start_b, in_valid_b, in_ready_b, in_last_b, out_valid_b, out_ready_b, busy_b;
    logic [7:0] in_data_b, max_val_b, min_val_b;
    logic [0:0] max_idx_b, min_idx_b;
    logic [1:0] count_b;

    signed_minmax_controller #(.SIZE(8), .COUNT(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a), .in_last(in_last_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .max_val(max_val_a), .min_val(min_val_a), .max_idx(max_idx_a), .min_idx(min_idx_a),
        .count(count_a), .busy(busy_a)
    );

    signed_minmax_controller #(.SIZE(8), .COUNT(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_last(in_last_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .max_val(max_val_b), .min_val(min_val_b), .max_idx(max_idx_b), .min_idx(min_idx_b),
        .count(count_b), .busy(busy_b)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int frame_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: scan the accepted samples, strictly-greater wins, first index kept on ties.
    task automatic model_result(output int mx, output int mxi, output int mn, output int mni,
                                output int cnt);
        mx = 0; mxi = 0; mn = 0; mni = 0;
        cnt = frame_q.size();
        for (int i = 0; i < frame_q.size(); i++) begin
            if (i == 0 || frame_q[i] > mx) begin mx = frame_q[i]; mxi = i; end
            if (i == 0 || frame_q[i] < mn) begin mn = frame_q[i]; mni = i; end
        end
    endtask

    always @(negedge clk) begin
        int mx, mxi, mn, mni, cnt;
        if (!rst && out_valid_a) begin
            model_result(mx, mxi, mn, mni, cnt);
            check("model_max_val", $signed(max_val_a), mx);
            check("model_max_idx", int'(max_idx_a), mxi);
            check("model_min_val", $signed(min_val_a), mn);
            check("model_min_idx", int'(min_idx_a), mni);
            check("model_count", int'(count_a), cnt);
        end
    end

    task automatic expect_a(input string tag, input int mx, input int mxi, input int mn,
                            input int mni, input int cnt);
        check({tag, "_max_val"}, $signed(max_val_a), mx);
        check({tag, "_max_idx"}, int'(max_idx_a), mxi);
        check({tag, "_min_val"}, $signed(min_val_a), mn);
        check({tag, "_min_idx"}, int'(min_idx_a), mni);
        check({tag, "_count"}, int'(count_a), cnt);
    endtask

    // All tasks below are entered and left on a falling edge.
    task automatic start_frame_a();
        frame_q.delete();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("start_busy", int'(busy_a), 1);
    endtask

    task automatic send_a(input int d, input bit last);
        bit ok;
        ok = 1'b0;
        in_valid_a = 1'b1;
        in_data_a  = d[7:0];
        in_last_a  = last;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (in_ready_a) begin
                @(posedge clk);
                frame_q.push_back(d);
                ok = 1'b1;
            end else begin
                @(posedge clk);
            end
        end
        @(negedge clk);
        in_valid_a = 1'b0;
        in_last_a  = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic finish_out_a();
        out_ready_a = 1'b1;
        @(negedge clk);
        out_ready_a = 1'b0;
        check("out_hs_idle_busy", int'(busy_a), 0);
        check("out_hs_idle_valid", int'(out_valid_a), 0);
    endtask

    initial begin
        rst = 1'b1;
        start_a = 0; in_valid_a = 0; in_data_a = 0; in_last_a = 0; out_ready_a = 0;
        start_b = 0; in_valid_b = 0; in_data_b = 0; in_last_b = 0; out_ready_b = 0;

        @(negedge clk);
        check("rst_busy", int'(busy_a), 0);
        check("rst_in_ready", int'(in_ready_a), 0);
        check("rst_out_valid", int'(out_valid_a), 0);
        expect_a("rst", 0, 0, 0, 0, 0);

        // start on the first edge after reset release
        rst = 1'b0;
        start_frame_a();
        check("first_in_ready", int'(in_ready_a), 1);
        send_a(5, 0);
        send_a(-3, 0);
        send_a(127, 0);
        check("pre_done_out_valid", int'(out_valid_a), 0);
        send_a(-128, 0);
        check("done_out_valid", int'(out_valid_a), 1);
        check("done_in_ready", int'(in_ready_a), 0);
        expect_a("f1", 127, 2, -128, 3, 4);
        finish_out_a();
        expect_a("f1_hold_idle", 127, 2, -128, 3, 4);

        // all ties: earliest index retained
        start_frame_a();
        send_a(7, 0); send_a(7, 0); send_a(7, 0); send_a(7, 1);
        expect_a("ties", 7, 0, 7, 0, 4);
        finish_out_a();

        // early in_last
        start_frame_a();
        send_a(-1, 0);
        send_a(0, 1);
        check("last_in_ready_drop", int'(in_ready_a), 0);
        check("last_out_valid", int'(out_valid_a), 1);
        expect_a("last", 0, 1, -1, 0, 2);
        finish_out_a();

        // input gaps stall, then DONE held with start pulses ignored
        start_frame_a();
        send_a(-20, 0);
        repeat (2) begin
            @(negedge clk);
            check("gap_count", int'(count_a), 1);
            check("gap_in_ready", int'(in_ready_a), 1);
        end
        send_a(40, 0);
        send_a(-5, 1);
        for (int i = 0; i < 3; i++) begin
            start_a = (i != 1);
            @(negedge clk);
            check("hold_out_valid", int'(out_valid_a), 1);
            expect_a("hold", 40, 1, -20, 0, 3);
        end
        start_a = 1'b1;
        out_ready_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        out_ready_a = 1'b0;
        check("hold_release_busy", int'(busy_a), 0);
        @(negedge clk);
        check("start_at_out_hs_ignored", int'(busy_a), 0);

        // mid-frame async reset
        start_frame_a();
        send_a(10, 0);
        send_a(20, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", int'(busy_a), 0);
        check("arst_in_ready", int'(in_ready_a), 0);
        check("arst_out_valid", int'(out_valid_a), 0);
        expect_a("arst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        start_frame_a();
        send_a(-50, 0); send_a(60, 0); send_a(0, 0); send_a(1, 0);
        expect_a("post_rst", 60, 1, -50, 0, 4);
        finish_out_a();

        // COUNT=1 instance, two idle input cycles before the only sample
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (2) begin
            check("b_gap_in_ready", int'(in_ready_b), 1);
            check("b_gap_out_valid", int'(out_valid_b), 0);
            @(negedge clk);
        end
        in_valid_b = 1'b1;
        in_data_b  = 8'h80;
        @(negedge clk);
        in_valid_b = 1'b0;
        check("b_out_valid", int'(out_valid_b), 1);
        check("b_in_ready", int'(in_ready_b), 0);
        check("b_max_val", $signed(max_val_b), -128);
        check("b_min_val", $signed(min_val_b), -128);
        check("b_count", int'(count_b), 1);
        out_ready_b = 1'b1;
        @(negedge clk);
        out_ready_b = 1'b0;
        check("b_idle_busy", int'(busy_b), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/signed_minmax_controller.md
SIGNED_MINMAX_CONTROLLER -- requirements
Module: signed_minmax_controller

Interface
REQ-001 Parameter SIZE, default 8: operand width in bits, two's complement; legal range is 2 or more.
REQ-002 Parameter COUNT, default 8: maximum samples per frame; legal range is 1 or more.
REQ-003 Localparam IDX_W = max(1, $clog2(COUNT)): width of the index outputs.
REQ-004 Ports SHALL be, in order:
  clk        input   1          sole clock, rising edge
  rst        input   1          asynchronous, active-high reset
  start      input   1          frame request, sampled in IDLE only
  in_valid   input   1          sample offered
  in_ready   output  1          sample accepted when in_valid and in_ready are both high
  in_data    input   SIZE       signed sample
  in_last    input   1          marks the accepted sample as final in the frame
  out_valid  output  1          result available
  out_ready  input   1          result consumed when out_valid and out_ready are both high
  max_val    output  SIZE       largest signed sample in the frame
  min_val    output  SIZE       smallest signed sample in the frame
  max_idx    output  IDX_W      position of max_val within the frame (0-based)
  min_idx    output  IDX_W      position of min_val within the frame (0-based)
  count      output  IDX_W+1    number of samples accepted in the frame
  busy       output  1          high in every state except IDLE

Function
REQ-005 The FSM SHALL have four states: IDLE, FIRST, ACCUM and DONE.
REQ-006 IDLE: if start is high, go to FIRST; otherwise stay in IDLE. While in IDLE, in_ready and out_valid SHALL be 0.
REQ-007 FIRST: in_ready=1. On a handshake, load max_val=min_val=in_data, set max_idx=min_idx=0 and count=1.
REQ-008 FIRST, next state after a handshake: DONE if in_last is high or COUNT==1; otherwise ACCUM.
REQ-009 ACCUM: in_ready=1. On each handshake, count increments by 1.
REQ-010 ACCUM: if in_data > max_val (signed compare), then max_val=in_data and max_idx=count, using the pre-increment value of count.
REQ-011 ACCUM: if min_val > in_data (signed compare), then min_val=in_data and min_idx=count, using the pre-increment value of count.
REQ-012 Ties SHALL NOT update max or min, so the earliest index wins.
REQ-013 ACCUM: go to DONE on a handshake where in_last is high, or where the incremented count equals COUNT.
REQ-014 in_last is ignored except on a handshake cycle.
REQ-015 DONE: out_valid=1 and in_ready=0. All result outputs SHALL stay stable until the out handshake.
REQ-016 On the out handshake, go to IDLE. A start in that same cycle is ignored, so a new frame needs start in IDLE.
REQ-017 A start while busy SHALL be ignored.
REQ-018 Gaps in in_valid SHALL stall the frame with no change to state or results.
REQ-019 Per-sample latency SHALL be one clock. Results are visible on out_valid one cycle after the final handshake.
REQ-020 No combinational path from in_valid or in_data to in_ready. in_ready depends on state only.
REQ-021 Result outputs SHALL hold their last values in IDLE until the next frame's first handshake.

Reset
REQ-022 While rst is high, all registers clear asynchronously: state=IDLE, and max_val, min_val, max_idx, min_idx and count are all 0.
REQ-023 Reset clears out_valid, in_ready and busy to 0, in any state including mid-frame. No partial result is emitted.
REQ-024 After rst is released, the block SHALL accept a new start on the first rising edge.

Structure
REQ-025 Package signed_minmax_pkg SHALL hold the state enum typedef (2-bit encoding) and the state localparams.
REQ-026 Signed compares SHALL use two instances of the existing signed_comparator sub-module with SIZE passed through:
  - one instance with a=in_data and b=max_val, whose is_a_greater drives the max update;
  - one instance with a=min_val and b=in_data, whose is_a_greater drives the min update.
REQ-027 No other arithmetic comparison operators are allowed in the datapath.

Verification
REQ-028 SIZE=8, COUNT=4, samples 5, -3, 127, -128 -> max_val=127, max_idx=2, min_val=-128, min_idx=3, count=4. out_valid rises one cycle after the 4th handshake.
REQ-029 Samples 7, 7, 7, 7 -> max_idx=0, min_idx=0, count=4, with max_val and min_val both 7.
REQ-030 Samples -1, then 0 with in_last=1 -> count=2, max_val=0, max_idx=1, min_val=-1, min_idx=0. in_ready drops the cycle after the 2nd handshake.
REQ-031 Hold out_ready=0 for 3 cycles in DONE while pulsing start -> out_valid stays 1, results stay unchanged, and the start is ignored. IDLE is reached one cycle after out_ready=1.
REQ-032 Assert rst after 2 samples of a frame -> all outputs are 0 immediately, without waiting for a clock edge. A following frame of -50, 60, 0, 1 yields max=60 at idx 1 and min=-50 at idx 0.
REQ-033 COUNT=1, sample -128 with in_valid gaps of 2 cycles before it -> state stays FIRST through the gaps, then DONE with max_val=min_val=-128 and count=1.
